// File: rtl/crc_frame_feeder.sv
// crc_frame_feeder: buffers parallel messages in a small FIFO and serialises each one
// MSB-first toward crcSender. Each message is followed by the trailing en strobes that
// clock out the remainder and the DONE state. Frames are separated by one idle cycle.
module crc_frame_feeder #(
  parameter int unsigned MSG_W        = 11,
  parameter int unsigned TRAIL_LEN    = 6,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [MSG_W-1:0]         in_data,
  output logic                     in_ready,
  output logic                     crc_en,
  output logic                     crc_bit,
  output logic                     busy,
  output logic                     frame_start,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned CW     = AW + 1;
  localparam int unsigned DW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned MaxLen = (MSG_W > TRAIL_LEN) ? MSG_W : TRAIL_LEN;
  localparam int unsigned BW     = $clog2(MaxLen);

  typedef enum logic [1:0] {StIdle, StSend, StTrail} state_e;

  logic [MSG_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;

  state_e           state_q, state_d;
  logic [DW-1:0]    div_q, div_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic [MSG_W-1:0] shift_q, shift_d;
  logic             frame_start_q, frame_start_d;

  logic push, pop, strobe;

  assign in_ready = (count_q != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  // Pop only from IDLE on the registered count; a word pushed this cycle is not visible yet.
  assign pop      = (state_q == StIdle) && (count_q != '0);
  assign strobe   = (div_q == DW'(CLKS_PER_BIT - 1));

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  // Serialiser state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      div_q         <= '0;
      bitcnt_q      <= '0;
      shift_q       <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      bitcnt_q      <= bitcnt_d;
      shift_q       <= shift_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Next-state: load on pop, shift and count on each strobe, trail strobes, then idle.
  always_comb begin
    state_d       = state_q;
    div_d         = div_q;
    bitcnt_d      = bitcnt_q;
    shift_d       = shift_q;
    frame_start_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          shift_d       = mem_q[rd_ptr_q];
          div_d         = '0;
          bitcnt_d      = '0;
          state_d       = StSend;
          frame_start_d = 1'b1;
        end
      end
      StSend: begin
        div_d = strobe ? '0 : div_q + DW'(1);
        if (strobe) begin
          shift_d = {shift_q[MSG_W-2:0], 1'b0};
          if (bitcnt_q == BW'(MSG_W - 1)) begin
            bitcnt_d = '0;
            state_d  = StTrail;
          end else begin
            bitcnt_d = bitcnt_q + BW'(1);
          end
        end
      end
      StTrail: begin
        div_d = strobe ? '0 : div_q + DW'(1);
        if (strobe) begin
          if (bitcnt_q == BW'(TRAIL_LEN - 1)) begin
            bitcnt_d = '0;
            state_d  = StIdle;
          end else begin
            bitcnt_d = bitcnt_q + BW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy        = (state_q != StIdle);
  assign crc_en      = busy && strobe;
  // Shift register only moves on strobes, so the bit holds for the whole bit period.
  assign crc_bit     = (state_q == StSend) ? shift_q[MSG_W-1] : 1'b0;
  assign frame_start = frame_start_q;
  assign fifo_count  = count_q;

endmodule
